// File: rtl/barcode_entry.sv
// barcode_entry: push-button front end of the sale terminal.
// Synchronizes and debounces four active-low keys, emits one-cycle press
// pulses, assembles a 4-digit BCD barcode and offers it downstream over a
// valid/ready handshake.
// Optional build macro: BARCODE_BACKSPACE_EN (KEY[0] with SW[0]=0 deletes the
// last digit instead of clearing the whole entry).
module barcode_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [3:0]  KEY,
    input  logic [2:0]  SW,
    input  logic        barcode_ready,
    output logic [15:0] barcode,
    output logic        barcode_valid,
    output logic [2:0]  digit_count,
    output logic [3:0]  key_pulse,
    output logic        entry_err
);

    // Last count value before a level change is accepted.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    logic [3:0]  key_meta_reg;
    logic [3:0]  key_sync_reg;
    logic [3:0]  key_level_reg;
    logic [3:0]  key_armed_reg;
    logic [7:0]  db_cnt_reg [4];
    logic [3:0]  press_det;
    logic [3:0]  key_pulse_reg;
    logic [1:0]  flush_reg;
    logic        sw_meta_reg;
    logic        sw_sync_reg;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] barcode_reg;
    logic [15:0] barcode_next;
    logic [2:0]  count_reg;
    logic [2:0]  count_next;
    logic        err_reg;
    logic        err_next;

    logic        digit_hit;
    logic [3:0]  digit_val;

    // SW[2:1] carry no function in this block.
    logic unused_sw;
    assign unused_sw = ^SW[2:1];

    // Tracks how many edges since reset, so we know when key_sync_reg holds a real sample.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            flush_reg <= 2'b00;
        end else begin
            flush_reg <= {flush_reg[0], 1'b1};
        end
    end

    // Two-flop synchronizers for the keys and the confirm-mode switch.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_meta_reg <= 4'hF;
            key_sync_reg <= 4'hF;
            sw_meta_reg  <= 1'b1;
            sw_sync_reg  <= 1'b1;
        end else begin
            key_meta_reg <= KEY;
            key_sync_reg <= key_meta_reg;
            sw_meta_reg  <= SW[0];
            sw_sync_reg  <= sw_meta_reg;
        end
    end

    // Per-key debouncer. A key only becomes armed once a genuine released
    // sample is seen after reset, so a key held through reset must be
    // released and pressed again before it can register.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            assign press_det[gi] = key_armed_reg[gi] && key_level_reg[gi]
                                   && !key_sync_reg[gi] && (db_cnt_reg[gi] == DB_LAST);

            // Stable level follows the synchronized sample after DEBOUNCE_CYCLES differing samples.
            always_ff @(posedge CLOCK_50) begin
                if (RESET) begin
                    key_level_reg[gi] <= 1'b1;
                    key_armed_reg[gi] <= 1'b0;
                    db_cnt_reg[gi]    <= 8'd0;
                end else begin
                    if (flush_reg[1] && key_sync_reg[gi]) begin
                        key_armed_reg[gi] <= 1'b1;
                    end
                    if (!key_armed_reg[gi] || (key_sync_reg[gi] == key_level_reg[gi])) begin
                        db_cnt_reg[gi] <= 8'd0;
                    end else if (db_cnt_reg[gi] == DB_LAST) begin
                        key_level_reg[gi] <= key_sync_reg[gi];
                        db_cnt_reg[gi]    <= 8'd0;
                    end else begin
                        db_cnt_reg[gi] <= db_cnt_reg[gi] + 8'd1;
                    end
                end
            end
        end
    endgenerate

    // Press pulses are registered on the same edge the stable level falls.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_pulse_reg <= 4'h0;
        end else begin
            key_pulse_reg <= press_det;
        end
    end

    // Highest-priority digit key among those pulsing this cycle.
    always_comb begin
        digit_hit = 1'b1;
        digit_val = 4'd0;
        if (key_pulse_reg[3]) begin
            digit_val = 4'd1;
        end else if (key_pulse_reg[2]) begin
            digit_val = 4'd2;
        end else if (key_pulse_reg[1]) begin
            digit_val = 4'd3;
        end else begin
            digit_hit = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: confirm a full code, release it on handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: begin
                if (key_pulse_reg[0] && sw_sync_reg && (count_reg == 3'd4)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (barcode_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Barcode assembly, clear/backspace and error detection.
    always_comb begin
        barcode_next = barcode_reg;
        count_next   = count_reg;
        err_next     = 1'b0;
        if (state_reg == HOLD) begin
            if (barcode_ready) begin
                barcode_next = 16'h0000;
                count_next   = 3'd0;
            end
        end else if (key_pulse_reg[0]) begin
            if (sw_sync_reg) begin
                if (count_reg != 3'd4) begin
                    err_next = 1'b1;
                end
            end else begin
`ifdef BARCODE_BACKSPACE_EN
                if (count_reg != 3'd0) begin
                    case (count_reg)
                        3'd1:    barcode_next[15:12] = 4'h0;
                        3'd2:    barcode_next[11:8]  = 4'h0;
                        3'd3:    barcode_next[7:4]   = 4'h0;
                        default: barcode_next[3:0]   = 4'h0;
                    endcase
                    count_next = count_reg - 3'd1;
                end
`else
                barcode_next = 16'h0000;
                count_next   = 3'd0;
`endif
            end
        end else if (digit_hit) begin
            case (count_reg)
                3'd0:    barcode_next[15:12] = digit_val;
                3'd1:    barcode_next[11:8]  = digit_val;
                3'd2:    barcode_next[7:4]   = digit_val;
                3'd3:    barcode_next[3:0]   = digit_val;
                default: err_next            = 1'b1;
            endcase
            if (count_reg < 3'd4) begin
                count_next = count_reg + 3'd1;
            end
        end
    end

    // Datapath registers for the code under construction.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            barcode_reg <= 16'h0000;
            count_reg   <= 3'd0;
            err_reg     <= 1'b0;
        end else begin
            barcode_reg <= barcode_next;
            count_reg   <= count_next;
            err_reg     <= err_next;
        end
    end

    // Outputs come straight from registers; valid is purely the HOLD state.
    always_comb begin
        barcode       = barcode_reg;
        barcode_valid = (state_reg == HOLD);
        digit_count   = count_reg;
        key_pulse     = key_pulse_reg;
        entry_err     = err_reg;
    end

endmodule

// File: tb/tb_barcode_entry.sv
// Directed testbench for barcode_entry with hand-computed expectations.
module tb_barcode_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key = 4'hF;
    logic [2:0]  sw  = 3'b000;
    logic        ready = 1'b0;
    logic [15:0] barcode;
    logic        barcode_valid;
    logic [2:0]  digit_count;
    logic [3:0]  key_pulse;
    logic        entry_err;

    int tests_run = 0;
    int failures  = 0;

    int pulse_cnt [4] = '{0, 0, 0, 0};
    int err_cnt   = 0;
    int valid_cyc = 0;
    logic [15:0] valid_code = 16'h0;

    int snap_p, snap_e, snap_v;

    always #5 clk = ~clk;

    barcode_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .KEY          (key),
        .SW           (sw),
        .barcode_ready(ready),
        .barcode      (barcode),
        .barcode_valid(barcode_valid),
        .digit_count  (digit_count),
        .key_pulse    (key_pulse),
        .entry_err    (entry_err)
    );

    // Event monitors sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (key_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
        end
        if (entry_err) err_cnt <= err_cnt + 1;
        if (barcode_valid) begin
            valid_cyc  <= valid_cyc + 1;
            valid_code <= barcode;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic press(input int k, input int hold);
        @(negedge clk);
        key[k] = 1'b0;
        repeat (hold) @(negedge clk);
        key[k] = 1'b1;
        repeat (12) @(negedge clk);
        $display("[TB] press KEY%0d for %0d cycles: barcode=%h count=%0d valid=%0b",
                 k, hold, barcode, digit_count, barcode_valid);
    endtask

    task automatic enter_1213();
        press(3, 10);
        press(2, 10);
        press(3, 10);
        press(1, 10);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_barcode", 32'(barcode), 32'h0);
        check("rst_valid", 32'(barcode_valid), 32'h0);
        check("rst_count", 32'(digit_count), 32'h0);
        check("rst_pulse", 32'(key_pulse), 32'h0);
        check("rst_err", 32'(entry_err), 32'h0);

        // Full entry, confirm with ready already high
        ready = 1'b1;
        sw = 3'b001;
        enter_1213();
        check("t1_code", 32'(barcode), 32'h1213);
        check("t1_count", 32'(digit_count), 32'd4);
        snap_v = valid_cyc;
        press(0, 10);
        check("t1_valid_cycles", 32'(valid_cyc - snap_v), 32'd1);
        check("t1_valid_code", 32'(valid_code), 32'h1213);
        check("t1_count_after", 32'(digit_count), 32'd0);
        check("t1_code_after", 32'(barcode), 32'h0);

        // Backpressure: HOLD keeps code, presses still pulse
        ready = 1'b0;
        enter_1213();
        press(0, 10);
        check("t2_valid", 32'(barcode_valid), 32'h1);
        snap_p = pulse_cnt[2];
        press(2, 10);
        repeat (27) @(negedge clk);
        check("t2_valid_held", 32'(barcode_valid), 32'h1);
        check("t2_code_held", 32'(barcode), 32'h1213);
        check("t2_count_held", 32'(digit_count), 32'd4);
        check("t2_pulse2", 32'(pulse_cnt[2] - snap_p), 32'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_valid_drop", 32'(barcode_valid), 32'h0);
        check("t2_count_clear", 32'(digit_count), 32'd0);
        ready = 1'b0;

        // Early confirm and digit overflow
        do_reset();
        sw = 3'b001;
        press(3, 10);
        press(2, 10);
        snap_e = err_cnt;
        press(0, 10);
        check("t3_err_early", 32'(err_cnt - snap_e), 32'd1);
        check("t3_count_early", 32'(digit_count), 32'd2);
        check("t3_valid_early", 32'(barcode_valid), 32'h0);
        do_reset();
        snap_e = err_cnt;
        press(3, 10);
        press(3, 10);
        press(3, 10);
        press(3, 10);
        press(1, 10);
        check("t3_overflow_code", 32'(barcode), 32'h1111);
        check("t3_overflow_err", 32'(err_cnt - snap_e), 32'd1);
        check("t3_overflow_count", 32'(digit_count), 32'd4);

        // Glitch rejection and exact press latency
        do_reset();
        snap_p = pulse_cnt[3];
        press(3, 3);
        check("t4_glitch_pulse", 32'(pulse_cnt[3] - snap_p), 32'd0);
        check("t4_glitch_count", 32'(digit_count), 32'd0);
        @(negedge clk);
        key[3] = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("t4_lat_edge%0d", i), 32'(key_pulse[3]), (i == 5) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        key[3] = 1'b1;
        repeat (12) @(negedge clk);
        check("t4_code", 32'(barcode), 32'h1000);
        check("t4_count", 32'(digit_count), 32'd1);

        // Clear / backspace with SW[0]=0
        do_reset();
        press(3, 10);
        press(2, 10);
        press(1, 10);
        sw = 3'b000;
        snap_e = err_cnt;
        press(0, 10);
`ifdef BARCODE_BACKSPACE_EN
        check("t5_code", 32'(barcode), 32'h1200);
        check("t5_count", 32'(digit_count), 32'd2);
`else
        check("t5_code", 32'(barcode), 32'h0);
        check("t5_count", 32'(digit_count), 32'd0);
`endif
        check("t5_err", 32'(err_cnt - snap_e), 32'd0);

        // Reset mid-entry with KEY[3] held
        press(3, 10);
        press(2, 10);
        @(negedge clk);
        key[3] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_code", 32'(barcode), 32'h0);
        check("t6_count", 32'(digit_count), 32'd0);
        check("t6_valid", 32'(barcode_valid), 32'h0);
        check("t6_pulse", 32'(key_pulse), 32'h0);
        check("t6_err", 32'(entry_err), 32'h0);
        snap_p = pulse_cnt[3];
        repeat (20) @(negedge clk);
        check("t6_held_pulse", 32'(pulse_cnt[3] - snap_p), 32'd0);
        check("t6_held_count", 32'(digit_count), 32'd0);
        key[3] = 1'b1;
        repeat (12) @(negedge clk);
        press(3, 10);
        check("t6_fresh_pulse", 32'(pulse_cnt[3] - snap_p), 32'd1);
        check("t6_fresh_code", 32'(barcode), 32'h1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/barcode_entry.md
# barcode_entry

Front-end input stage of the sale terminal. Conditions the four raw active-low push-buttons, assembles keyed digits into a 4-digit product barcode and hands the completed code to the product-lookup/sale logic over a valid/ready handshake. Also forwards one-cycle debounced press pulses for the interactive-select logic downstream.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a key level change; legal range 2..255.
- CLOCK_50  in  1  system clock, 50 MHz; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- KEY  in  4  raw push-buttons, active-low, asynchronous to CLOCK_50.
- SW  in  3  slide switches; only SW[0] (confirm mode) is used, SW[2:1] ignored.
- barcode_ready  in  1  downstream accepts barcode when high with barcode_valid.
- barcode  out  16  four BCD nibbles; first digit entered in [15:12].
- barcode_valid  out  1  completed barcode offered.
- digit_count  out  3  digits entered so far, 0..4; for HEX display.
- key_pulse  out  4  one-cycle pulse per debounced press, bit i for KEY[i].
- entry_err  out  1  one-cycle pulse on illegal confirm or digit overflow.

## Operation
- Per key: 2-FF synchronizer, then debouncer with 8-bit counter; stable level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differing from it; counter clears whenever sample equals stable level.
- Press = stable level 1->0; key_pulse[i] registered from that edge. Releases produce nothing.
- Digit map: KEY[3] -> 1, KEY[2] -> 2, KEY[1] -> 3. KEY[0] is the command key.
- FSM states: COLLECT, HOLD.
- COLLECT, digit press, digit_count<4: digit shifted into next nibble (nibble 3-digit_count), digit_count+1.
- COLLECT, digit press, digit_count==4: digit dropped, entry_err pulses.
- COLLECT, KEY[0] press, SW[0]=1, digit_count==4: -> HOLD, barcode_valid=1.
- COLLECT, KEY[0] press, SW[0]=1, digit_count<4: entry_err pulses, no state change.
- COLLECT, KEY[0] press, SW[0]=0: clear — barcode=0, digit_count=0.
- HOLD: barcode and barcode_valid stable; all presses ignored for assembly (key_pulse still emitted). On barcode_valid&&barcode_ready -> COLLECT, barcode=0, digit_count=0, barcode_valid=0.
- Simultaneous presses in one cycle: priority KEY[0] > KEY[3] > KEY[2] > KEY[1]; only highest acts on assembly, all key_pulse bits assert.
- SW[0] sampled in the cycle of the KEY[0] press pulse; 2-FF synchronized like KEY.

## Timing
- Reset values: barcode=0, barcode_valid=0, digit_count=0, key_pulse=0, entry_err=0, state COLLECT, debounced levels=1 (released), counters=0, synchronizers=1.
- Press latency: KEY[i] first sampled low at edge N and held -> key_pulse[i] high for exactly the cycle after edge N+1+DEBOUNCE_CYCLES.
- Assembly/error/valid update on the edge after the key_pulse cycle (one further cycle).
- Glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no pulse, no state change.
- Handshake: barcode_valid drops the cycle after the accepting edge; ready may be high before valid; no combinational ready->valid path.
- RESET mid-entry or in HOLD: all state to reset values at that edge; a key held through reset is treated as released and must produce a fresh press after reset deasserts (counter restarts).

## Configuration
- BARCODE_BACKSPACE_EN defined: KEY[0] press with SW[0]=0 in COLLECT removes last digit (its nibble zeroed, digit_count-1); at digit_count==0 does nothing, no entry_err.
- Undefined: KEY[0] press with SW[0]=0 clears all digits as above.

## Test plan
- Press KEY[3],KEY[2],KEY[3],KEY[1] (10 cycles each), SW[0]=1, press KEY[0], barcode_ready=1 -> barcode=16'h1213, barcode_valid high exactly 1 cycle, then digit_count=0.
- Same entry with barcode_ready=0 for 50 cycles, press KEY[2] meanwhile -> valid held, barcode stays 16'h1213, key_pulse[2] pulses; ready=1 -> valid drops next cycle.
- Enter 1,2 then SW[0]=1, KEY[0] -> entry_err 1 pulse, digit_count=2, no valid; enter 5 digits 1,1,1,1,3 -> barcode=16'h1111, one entry_err.
- KEY[3] low for 3 cycles (DEBOUNCE_CYCLES=4) -> no key_pulse; low for 6 cycles -> one pulse at edge N+5 cycle.
- Enter 1,2,3 then SW[0]=0, KEY[0] -> without macro barcode=0, digit_count=0; with BARCODE_BACKSPACE_EN barcode=16'h1200, digit_count=2.
- Enter 1,2, assert RESET 1 cycle while KEY[3] held low -> all outputs 0; no pulse until KEY[3] released and pressed again.
